// File: rtl/inst_mem_loader.sv
// inst_mem_loader
// Writer side of the instruction-memory port. Receives a framed byte stream
// (sync, word count, little-endian payload, XOR checksum), assembles 32-bit
// instruction words and writes them to consecutive word addresses. The core
// is held in reset until a complete frame has loaded with a good checksum.
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   byte_valid - byte_data holds a valid byte
//   byte_data  - incoming stream byte
//   byte_ready - loader accepts a byte this cycle (transfer on valid & ready)
//   wr_en      - instruction-memory write strobe, one cycle per word
//   wr_addr    - word address of the write
//   wr_data    - assembled instruction word
//   core_hold  - high while the core must be held in reset
//   busy       - a frame is in progress
//   done       - sticky: last frame loaded with a good checksum
//   error      - sticky: last frame failed (bad count or bad checksum)
module inst_mem_loader #(
  parameter int         INST_WIDTH                = 32,
  parameter int         INST_MEMORY_ADDRESS_WIDTH = 6,
  parameter logic [7:0] SYNC_BYTE                 = 8'hA5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 byte_valid,
  input  logic [7:0]                           byte_data,
  output logic                                 byte_ready,
  output logic                                 wr_en,
  output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] wr_addr,
  output logic [INST_WIDTH-1:0]                wr_data,
  output logic                                 core_hold,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  localparam int AW    = INST_MEMORY_ADDRESS_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] word_total;
  logic [CW-1:0] words_written;
  logic [1:0]    byte_idx;
  logic [7:0]    xor_acc;
  logic          accept;

  // A byte transfers only when the host offers it and the loader is ready.
  assign accept = byte_valid && byte_ready;

  // Frame-parsing state machine with all outputs registered alongside the
  // state. DONE and ERROR last one cycle and behave like IDLE for incoming
  // bytes, so a sync byte arriving right after a checksum is never lost.
  // wr_addr only advances when another word follows, so it never wraps
  // even for a full-depth frame and keeps the last written address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      byte_ready    <= 1'b1;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      core_hold     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      word_total    <= '0;
      words_written <= '0;
      byte_idx      <= '0;
      xor_acc       <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b1;
          if (accept && byte_data == SYNC_BYTE) begin
            state     <= S_COUNT;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            wr_addr   <= '0;
            xor_acc   <= '0;
            core_hold <= 1'b1;
          end
        end

        S_COUNT: begin
          if (accept) begin
            if (byte_data == 8'd0 || int'(byte_data) > DEPTH) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              state         <= S_DATA;
              word_total    <= CW'(byte_data);
              words_written <= '0;
              byte_idx      <= '0;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            wr_data[{byte_idx, 3'b000} +: 8] <= byte_data;
            xor_acc  <= xor_acc ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state      <= S_WRITE;
              wr_en      <= 1'b1;
              byte_ready <= 1'b0;
            end
          end
        end

        S_WRITE: begin
          byte_ready    <= 1'b1;
          words_written <= words_written + CW'(1);
          if (words_written + CW'(1) == word_total) begin
            state <= S_CHECK;
          end else begin
            state   <= S_DATA;
            wr_addr <= wr_addr + AW'(1);
          end
        end

        S_CHECK: begin
          if (accept) begin
            if (byte_data == xor_acc) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader
// Self-checking bench for inst_mem_loader. Frames are built from lists of
// instruction words; the expected writes and final status are derived from
// the frame contents alone (word i lands at address i, checksum is the XOR
// of all payload bytes, count must be 1..64).
module tb_inst_mem_loader;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  int          errors  = 0;
  int          checks  = 0;
  int          max_gap = 0;
  wr_t         observed_q[$];
  logic [31:0] frame_words[$];

  inst_mem_loader #(
    .INST_WIDTH(32),
    .INST_MEMORY_ADDRESS_WIDTH(6),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .core_hold(core_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Record every write strobe and watch the per-cycle invariants: the loader
  // stalls the stream exactly while it writes, and done/error never coexist.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) observed_q.push_back({wr_addr, wr_data});
      checkOutput("ready_vs_wren", 32'(byte_ready), 32'(!wr_en));
      checkOutput("done_error_excl", 32'(done & error), 32'd0);
    end
  end

  // Offer one byte after a random idle gap and hold it until accepted.
  task automatic applyStimulus(input logic [7:0] b);
    bit accepted = 1'b0;
    int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 30 && !accepted; i++) begin
      @(negedge clk);
      if (byte_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Wait until the loader has returned to idle, bounded.
  task automatic waitIdle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 50 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) checkOutput({tag, "_idle_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Check every output against its reset value.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
    checkOutput({tag, "_wr_en"},      32'(wr_en),      32'd0);
    checkOutput({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    checkOutput({tag, "_wr_data"},    wr_data,         32'd0);
    checkOutput({tag, "_core_hold"},  32'(core_hold),  32'd1);
    checkOutput({tag, "_busy"},       32'(busy),       32'd0);
    checkOutput({tag, "_done"},       32'(done),       32'd0);
    checkOutput({tag, "_error"},      32'(error),      32'd0);
  endtask

  // Send one frame built from frame_words and compare the resulting writes
  // and status with what the frame rules predict.
  task automatic runFrame(input string tag, input logic [7:0] count_byte,
                          input bit corrupt);
    logic [7:0] cks = 8'h00;
    logic [7:0] b;
    bit count_ok = (count_byte != 8'd0) && (count_byte <= 8'd64);
    bit good     = count_ok && !corrupt;
    int n_exp    = count_ok ? frame_words.size() : 0;
    int n_obs;
    observed_q.delete();
    applyStimulus(8'hA5);
    applyStimulus(count_byte);
    if (count_ok) begin
      for (int w = 0; w < frame_words.size(); w++) begin
        for (int k = 0; k < 4; k++) begin
          b   = 8'(frame_words[w] >> (8 * k));
          cks = cks ^ b;
          applyStimulus(b);
        end
      end
      applyStimulus(corrupt ? ~cks : cks);
    end
    waitIdle(tag);
    n_obs = observed_q.size();
    checkOutput({tag, "_nwrites"}, 32'(n_obs), 32'(n_exp));
    for (int i = 0; i < n_obs && i < n_exp; i++) begin
      checkOutput({tag, "_addr"}, 32'(observed_q[i].addr), 32'(i));
      checkOutput({tag, "_data"}, observed_q[i].data, frame_words[i]);
    end
    checkOutput({tag, "_done"},      32'(done),      32'(good));
    checkOutput({tag, "_error"},     32'(error),     32'(!good));
    checkOutput({tag, "_core_hold"}, 32'(core_hold), 32'(!good));
    checkOutput({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Fill frame_words with n random instruction words.
  task automatic randomWords(input int n);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back($urandom);
  endtask

  // Directed sequence of scenarios, from reset through faults and gaps.
  initial begin
    logic [7:0] b2;
    int n;
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkResetValues("after_reset");

    frame_words = '{32'h0000_0013};
    runFrame("one_word", 8'd1, 1'b0);

    frame_words = '{32'h0050_0093, 32'h0010_8113};
    runFrame("two_words", 8'd2, 1'b0);
    runFrame("bad_checksum", 8'd2, 1'b1);

    frame_words.delete();
    runFrame("count_65", 8'h41, 1'b0);
    runFrame("count_0", 8'h00, 1'b0);

    randomWords(3);
    runFrame("after_bad_count", 8'd3, 1'b0);

    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("garbage_busy", 32'(busy), 32'd0);
    frame_words = '{32'h0050_0093, 32'h0010_8113};
    runFrame("after_garbage", 8'd2, 1'b0);

    max_gap = 5;
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(1, 8));
      randomWords(n);
      runFrame("random_gap", 8'(n), ($urandom_range(0, 3) == 0));
    end
    randomWords(64);
    runFrame("full_depth", 8'd64, 1'b0);
    max_gap = 0;

    randomWords(2);
    applyStimulus(8'hA5);
    applyStimulus(8'd2);
    applyStimulus(frame_words[0][7:0]);
    applyStimulus(frame_words[0][15:8]);
    b2         = frame_words[0][23:16];
    byte_valid = 1'b1;
    byte_data  = b2;
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_reset");
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    randomWords(2);
    runFrame("after_mid_reset", 8'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
